// File: rtl/qtz_seg_sequencer.sv
// Segment sequencer for the quantizer-output mux: fetches each item-memory segment,
// then strobes the segment select so the mux loads the level HVs for that segment.
module qtz_seg_sequencer #(
    parameter int FEATURE_COUNT = 617,
    parameter int SEG_WIDTH     = 62,
    parameter int NUM_SEGS      = 10,
    parameter int SEL_W         = 4,
    parameter int IDX_W         = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic             fetch_req,
    input  logic             fetch_ack,
    output logic [IDX_W-1:0] feature_base,
    output logic [5:0]       seg_len,
    output logic [SEL_W-1:0] sel,
    output logic             seg_wr_en,
    output logic             busy,
    output logic             done,
    output logic             proto_err
);

    localparam logic [5:0]       FULL_LEN = 6'(SEG_WIDTH);
    localparam logic [5:0]       LAST_LEN = 6'(FEATURE_COUNT - (NUM_SEGS - 1) * SEG_WIDTH);
    localparam logic [5:0]       FIRST_LEN = (NUM_SEGS == 1) ? LAST_LEN : FULL_LEN;
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_SEGS - 1);
    localparam logic [IDX_W-1:0] BASE_STEP = IDX_W'(SEG_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WRITE,
        ST_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [IDX_W-1:0]   base_q, base_d;
    logic [5:0]         len_q, len_d;
    logic               fetch_req_q, fetch_req_d;
    logic               seg_wr_en_q, seg_wr_en_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               proto_err_q, proto_err_d;
    logic [SEL_W-1:0]   sel_inc;

    assign sel_inc = sel_q + SEL_W'(1);

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        base_d      = base_q;
        len_d       = len_q;
        proto_err_d = proto_err_q;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d     = ST_REQ;
                    sel_d       = '0;
                    base_d      = '0;
                    len_d       = FIRST_LEN;
                    proto_err_d = 1'b0;
                end
            end
            ST_REQ: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (fetch_ack) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (sel_q == SEL_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_REQ;
                    sel_d   = sel_inc;
                    base_d  = base_q + BASE_STEP;
                    len_d   = (sel_inc == SEL_LAST) ? LAST_LEN : FULL_LEN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A stray ack is flagged even on the cycle a start is accepted.
        if (fetch_ack && (state_q != ST_REQ)) begin
            proto_err_d = 1'b1;
        end

        fetch_req_d = (state_d == ST_REQ);
        seg_wr_en_d = (state_d == ST_WRITE);
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            base_q      <= '0;
            len_q       <= FULL_LEN;
            fetch_req_q <= 1'b0;
            seg_wr_en_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            base_q      <= base_d;
            len_q       <= len_d;
            fetch_req_q <= fetch_req_d;
            seg_wr_en_q <= seg_wr_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign fetch_req    = fetch_req_q;
    assign seg_wr_en    = seg_wr_en_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign proto_err    = proto_err_q;
    assign sel          = sel_q;
    assign feature_base = base_q;
    assign seg_len      = len_q;

endmodule

// File: tb/tb_qtz_seg_sequencer.sv
// Bench for qtz_seg_sequencer: directed passes plus randomized ack delays, aborts and
// stray starts, checked against a cycle schedule derived from the latency rules.
module tb_qtz_seg_sequencer;

    localparam int FC = 617;
    localparam int SW = 62;
    localparam int NS = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic       fetch_req;
    logic       fetch_ack;
    logic [9:0] feature_base;
    logic [5:0] seg_len;
    logic [3:0] sel;
    logic       seg_wr_en;
    logic       busy;
    logic       done;
    logic       proto_err;

    int n_checks = 0;
    int n_errors = 0;
    int dly [NS];

    qtz_seg_sequencer #(
        .FEATURE_COUNT(FC),
        .SEG_WIDTH    (SW),
        .NUM_SEGS     (NS),
        .SEL_W        (4),
        .IDX_W        (10)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .fetch_req   (fetch_req),
        .fetch_ack   (fetch_ack),
        .feature_base(feature_base),
        .seg_len     (seg_len),
        .sel         (sel),
        .seg_wr_en   (seg_wr_en),
        .busy        (busy),
        .done        (done),
        .proto_err   (proto_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, "_busy"}, 32'(busy), 0);
        check_val({tag, "_req"}, 32'(fetch_req), 0);
        check_val({tag, "_wr"}, 32'(seg_wr_en), 0);
        check_val({tag, "_done"}, 32'(done), 0);
    endtask

    // Runs one pass starting in the current (idle) cycle, which is cycle 0.
    // Segment k requests from r[k], is acked at a[k] = r[k] + dly[k], writes at a[k]+1,
    // and the next request follows the write. abort_seg < 0 disables the abort.
    task automatic run_pass(input int abort_seg, input int abort_off, input int sp_seg,
                            output int done_seen, output int wr_cnt);
        int r [NS];
        int a [NS];
        int w [NS];
        int done_c, abort_c, end_c, sp_c;
        bit req_e, wr_e, live;
        int kw;
        r[0] = 1;
        for (int k = 0; k < NS; k++) begin
            if (k > 0) r[k] = w[k-1] + 1;
            a[k] = r[k] + dly[k];
            w[k] = a[k] + 1;
        end
        done_c  = w[NS-1] + 1;
        abort_c = (abort_seg >= 0) ? r[abort_seg] + abort_off : 1 << 30;
        end_c   = (abort_seg >= 0) ? abort_c + 1 : done_c + 1;
        sp_c    = (sp_seg >= 0) ? r[sp_seg] : -1;
        done_seen = -1;
        wr_cnt    = 0;
        start = 1'b1;
        fetch_ack = 1'b0;
        abort = 1'b0;
        for (int c = 1; c <= end_c; c++) begin
            tick();
            start = 1'b0;
            fetch_ack = 1'b0;
            abort = 1'b0;
            live  = (c <= abort_c);
            req_e = 1'b0;
            wr_e  = 1'b0;
            kw    = 0;
            for (int k = 0; k < NS; k++) begin
                if (c >= r[k] && c <= a[k]) req_e = live;
                if (c == w[k]) begin
                    wr_e = live;
                    kw   = k;
                end
            end
            check_val("fetch_req", 32'(fetch_req), 32'(req_e));
            check_val("seg_wr_en", 32'(seg_wr_en), 32'(wr_e));
            check_val("done", 32'(done), 32'(live && c == done_c));
            check_val("busy", 32'(busy), 32'(live && c <= done_c));
            check_val("proto_err", 32'(proto_err), 0);
            check_val("sel_range", 32'(sel <= 4'(NS - 1)), 1);
            if (wr_e) begin
                check_val("wr_sel", 32'(sel), 32'(kw));
                check_val("wr_base", 32'(feature_base), 32'(kw * SW));
                check_val("wr_len", 32'(seg_len), 32'((FC - kw * SW < SW) ? FC - kw * SW : SW));
            end
            if (seg_wr_en) wr_cnt++;
            if (done) done_seen = c;
            for (int k = 0; k < NS; k++) begin
                if (c == a[k] && c <= abort_c) fetch_ack = 1'b1;
            end
            if (c == abort_c) abort = 1'b1;
            if (c == sp_c) start = 1'b1;
        end
        start = 1'b0;
        fetch_ack = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        int done_seen, wr_cnt, ab_seg, ab_off, sp_seg;
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        fetch_ack = 1'b0;
        #12;
        check_idle("rst");
        check_val("rst_sel", 32'(sel), 0);
        check_val("rst_base", 32'(feature_base), 0);
        check_val("rst_len", 32'(seg_len), SW);
        check_val("rst_perr", 32'(proto_err), 0);
        rst = 1'b0;
        tick();

        // Zero-wait acks: writes at 2..20, done at 21.
        for (int k = 0; k < NS; k++) dly[k] = 0;
        run_pass(-1, 0, -1, done_seen, wr_cnt);
        check_val("t1_done_cyc", done_seen, 21);
        check_val("t1_wr_cnt", wr_cnt, 10);

        // Segment 4 acked three cycles late.
        dly[4] = 3;
        run_pass(-1, 0, -1, done_seen, wr_cnt);
        check_val("t2_done_cyc", done_seen, 24);
        check_val("t2_wr_cnt", wr_cnt, 10);
        dly[4] = 0;

        // Abort coincident with the segment-5 ack.
        run_pass(5, 0, -1, done_seen, wr_cnt);
        check_val("t3_done_cyc", done_seen, -1);
        check_val("t3_wr_cnt", wr_cnt, 5);

        // Start while busy is ignored.
        run_pass(-1, 0, 3, done_seen, wr_cnt);
        check_val("t4_done_cyc", done_seen, 21);
        check_val("t4_wr_cnt", wr_cnt, 10);

        // Abort in IDLE blocks start.
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check_idle("abort_idle");
        tick();
        check_idle("abort_idle2");

        // Stray ack in IDLE sets the sticky error; the next start clears it.
        fetch_ack = 1'b1;
        tick();
        fetch_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_val("perr_sticky", 32'(proto_err), 1);
            check_idle("perr_idle");
            tick();
        end
        run_pass(-1, 0, -1, done_seen, wr_cnt);
        check_val("t5_done_cyc", done_seen, 21);

        // Asynchronous reset in the WRITE cycle of segment 7 (cycle 16).
        start = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            tick();
            start = 1'b0;
            fetch_ack = fetch_req;
        end
        check_val("t6_pre_wr", 32'(seg_wr_en), 1);
        check_val("t6_pre_sel", 32'(sel), 7);
        #2;
        rst = 1'b1;
        #1;
        check_idle("t6_rst");
        check_val("t6_rst_sel", 32'(sel), 0);
        check_val("t6_rst_base", 32'(feature_base), 0);
        check_val("t6_rst_len", 32'(seg_len), SW);
        #2;
        rst = 1'b0;
        fetch_ack = 1'b0;
        tick();
        check_idle("t6_post");
        run_pass(-1, 0, -1, done_seen, wr_cnt);
        check_val("t6_done_cyc", done_seen, 21);
        check_val("t6_wr_cnt", wr_cnt, 10);

        // Randomized passes: ack delays, occasional aborts and stray starts.
        for (int p = 0; p < 12; p++) begin
            for (int k = 0; k < NS; k++) dly[k] = int'($urandom_range(3, 0));
            ab_seg = -1;
            ab_off = 0;
            if ($urandom_range(2, 0) == 0) begin
                ab_seg = int'($urandom_range(NS - 1, 0));
                ab_off = int'($urandom_range(dly[ab_seg], 0));
            end
            sp_seg = ($urandom_range(1, 0) == 1) ? int'($urandom_range(NS - 1, 0)) : -1;
            if (ab_seg >= 0 && sp_seg > ab_seg) sp_seg = -1;
            run_pass(ab_seg, ab_off, sp_seg, done_seen, wr_cnt);
            check_val("rnd_wr_cnt", wr_cnt, (ab_seg >= 0) ? ab_seg : NS);
            for (int i = 0; i < int'($urandom_range(2, 0)); i++) begin
                tick();
                check_idle("rnd_gap");
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/qtz_seg_sequencer.md
Name: qtz_seg_sequencer

Overview:
Control stage directly upstream of the quantizer-output segment mux. It walks the feature vector segment by segment. For each segment it:
- requests one item-memory fetch;
- waits for the fetch acknowledge;
- drives the segment select plus a one-cycle write strobe, which the mux decodes into the one-hot register enable that loads level HVs.

It also produces the feature base index and valid length for each segment. It reports busy/done to the encoder top-level controller.

Parameters:
FEATURE_COUNT, 617, total features to map
SEG_WIDTH, 62, features per fetch segment
NUM_SEGS, 10, number of segments; legal iff (NUM_SEGS-1)*SEG_WIDTH < FEATURE_COUNT <= NUM_SEGS*SEG_WIDTH
SEL_W, 4, width of sel; must be >= clog2(NUM_SEGS)
IDX_W, 10, width of feature_base; must be >= clog2(FEATURE_COUNT)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
start  input  1  begin a mapping pass; sampled only in IDLE
abort  input  1  synchronous cancel of a pass in progress
fetch_req  output  1  request to item-memory fetch; held until fetch_ack
fetch_ack  input  1  fetch complete; fetch outputs stable until next fetch_req rise
feature_base  output  IDX_W  first feature index of current segment
seg_len  output  6  valid features in current segment (SEG_WIDTH, or remainder on last)
sel  output  SEL_W  segment index to mux
seg_wr_en  output  1  one-cycle write qualifier for mux-enabled registers
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse on pass completion
proto_err  output  1  sticky: fetch_ack seen outside REQ

Behaviour:
- Reset values:
  - state=IDLE;
  - fetch_req, seg_wr_en, busy, done, proto_err = 0;
  - sel, feature_base = 0;
  - seg_len = SEG_WIDTH.
- All outputs are registered.
- States: IDLE, REQ, WRITE, DONE.
- IDLE:
  - start=1 and abort=0 -> REQ.
  - On that transition: sel=0, feature_base=0, seg_len=SEG_WIDTH, proto_err cleared.
  - First fetch_req is high the cycle after start.
- REQ:
  - fetch_req=1.
  - fetch_ack=1 -> WRITE.
  - fetch_ack=0 -> stay in REQ indefinitely; there is no timeout.
- WRITE:
  - seg_wr_en=1 for exactly this cycle, fetch_req=0.
  - sel, feature_base and seg_len are stable for the whole cycle.
  - If sel==NUM_SEGS-1 -> DONE.
  - Otherwise -> REQ, with sel+1, feature_base+SEG_WIDTH, and seg_len set for the new index.
- DONE: done=1 for one cycle -> IDLE. sel and feature_base hold their last values until the next start.
- seg_len:
  - SEG_WIDTH when sel<NUM_SEGS-1.
  - FEATURE_COUNT-(NUM_SEGS-1)*SEG_WIDTH when sel==NUM_SEGS-1 (59 at defaults).
- Latency:
  - fetch_ack in cycle n gives seg_wr_en in cycle n+1.
  - With zero-wait acks, start in cycle 0 gives done in cycle 2*NUM_SEGS+1 (21 at defaults).
- Event precedence:
  - abort in any non-IDLE state -> IDLE next cycle.
  - On abort: no seg_wr_en or done is issued that cycle or later; fetch_req drops the next cycle.
  - abort=1 in IDLE blocks start.
  - abort coincident with fetch_ack in REQ: abort wins, no write.
  - start while busy is ignored; the pass in progress is unaffected.
- proto_err:
  - Set if fetch_ack=1 in IDLE, WRITE or DONE; the stray ack is otherwise ignored.
  - Cleared only by rst or an accepted start.
- rst mid-pass: all outputs return to reset values asynchronously; no done is issued.
- sel never exceeds NUM_SEGS-1.
- feature_base never exceeds (NUM_SEGS-1)*SEG_WIDTH (558 at defaults).

Test Plan:
- Full pass, fetch_ack tied to fetch_req, start at cycle 0 -> all of the following:
  - seg_wr_en pulses in cycles 2,4,…,20;
  - sel=0..9 on those pulses;
  - feature_base=0,62,…,558;
  - seg_len=62 except 59 on sel=9;
  - done in cycle 21;
  - busy high cycles 1–21.
- Ack delayed 3 cycles on segment 4 -> fetch_req held 4 cycles, sel stays 4, single seg_wr_en after the ack, done at cycle 24.
- abort asserted in REQ of segment 5, coincident with fetch_ack -> no seg_wr_en for sel=5, no done, busy=0 and fetch_req=0 next cycle.
- start pulsed in segment 3 while busy -> ignored; pass completes normally with exactly 10 seg_wr_en pulses.
- fetch_ack pulsed in IDLE -> proto_err=1 and stays 1; the next start clears it; state stays IDLE until that start.
- rst asserted asynchronously mid-WRITE of segment 7 -> seg_wr_en, busy, fetch_req, sel and feature_base immediately 0; a following start runs a full clean pass.
